text_overlay_renderer: RTL and testbench

- Pixel-pipeline stage directly upstream of the character ROM in the HUD/score text path.
- Holds a small character buffer written by game logic (score, lives, "GAME OVER").
- Maps incoming VGA pixel coordinates to a character cell, supplies char_code/row to the ROM, and serialises the returned 8-bit row_data into a per-pixel text_on flag.
- Sync and active signals are delayed to stay aligned with text_on.

---
 rtl/text_overlay_renderer.sv | 212 +++++++++++++++++++++
 tb/tb_text_overlay_renderer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_overlay_renderer.sv
// Text overlay renderer for the HUD/score path.
// Holds a small character buffer written by game logic, maps VGA pixel
// coordinates onto 8x16 character cells, drives the character ROM address
// and serialises the returned glyph row into a per-pixel text_on flag.
// Sync and active flags are delayed so they line up with text_on
// (2 cycles of latency from pixel coordinates to text_on).
module text_overlay_renderer #(
    parameter int         COLS       = 32,
    parameter int         ROWS       = 2,
    parameter int         ADDR_W     = 6,
    parameter int         ORIGIN_X   = 16,
    parameter int         ORIGIN_Y   = 8,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              video_active_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              clear,
    output logic              busy,
    output logic [7:0]        char_code,
    output logic [3:0]        char_row,
    input  logic [7:0]        row_data,
    output logic              text_on,
    output logic              video_active_out,
    output logic              hsync_out,
    output logic              vsync_out
);

    localparam int                DEPTH     = COLS * ROWS;
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_A   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [9:0]        ORG_X     = 10'(ORIGIN_X);
    localparam logic [9:0]        ORG_Y     = 10'(ORIGIN_Y);
    localparam logic [10:0]       WIN_W     = 11'(8 * COLS);
    localparam logic [10:0]       WIN_H     = 11'(16 * ROWS);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] clr_cnt_q;

    // Character buffer. Contents are set to BLANK_CHAR at configuration only.
    logic [7:0]        mem [DEPTH] = '{default: BLANK_CHAR};
    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [7:0]        mem_wdata;

    // C0: window test and cell addressing
    logic [9:0]        rel_x;
    logic [9:0]        rel_y;
    logic              in_win_c0;
    logic [15:0]       cell_idx;
    logic [IDX_W-1:0]  rd_idx;

    // C1 registers
    logic [7:0]        rd_data_q;
    logic [3:0]        glyph_row_q;
    logic [2:0]        x_bit_c1;
    logic              in_win_c1;
    logic              active_c1;
    logic              hsync_c1;
    logic              vsync_c1;

    // C2 registers
    logic [7:0]        row_data_q;
    logic [2:0]        x_bit_c2;
    logic              in_win_c2;
    logic              active_c2;
    logic              hsync_c2;
    logic              vsync_c2;

    // The origin is compared first so a pixel left of / above the window
    // cannot wrap into it through the subtraction.
    assign rel_x     = pixel_x - ORG_X;
    assign rel_y     = pixel_y - ORG_Y;
    assign in_win_c0 = (pixel_x >= ORG_X) && (pixel_y >= ORG_Y) &&
                       ({1'b0, rel_x} < WIN_W) && ({1'b0, rel_y} < WIN_H);
    assign cell_idx  = 16'(rel_y[9:4]) * 16'(COLS) + 16'(rel_x[9:3]);
    assign rd_idx    = in_win_c0 ? cell_idx[IDX_W-1:0] : '0;

    // Clear FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear FSM next state and busy flag
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an unassigned path infers a latch.
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                busy = 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clear address counter: parked at 0 in IDLE, walks the buffer in CLEAR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt_q <= '0;
        end else if (state_q == ST_IDLE) begin
            clr_cnt_q <= '0;
        end else begin
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
        end
    end

    // Write port arbitration: the clear sweep owns the port while busy,
    // otherwise in-range external writes go through.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = '0;
        mem_wdata = BLANK_CHAR;
        if (state_q == ST_CLEAR) begin
            mem_we   = 1'b1;
            mem_widx = clr_cnt_q[IDX_W-1:0];
        end else if (wr_en && ({1'b0, wr_addr} < DEPTH_A)) begin
            mem_we    = 1'b1;
            mem_widx  = wr_addr[IDX_W-1:0];
            mem_wdata = wr_data;
        end
    end

    // Buffer write port
    always_ff @(posedge clk) begin
        // NOTE: the RAM array is deliberately not reset; an async reset on a
        // memory prevents RAM inference and the contents must survive reset.
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    // C1 stage: registered buffer read plus the side information for the cell
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q   <= '0;
            glyph_row_q <= '0;
            x_bit_c1    <= '0;
            in_win_c1   <= 1'b0;
            active_c1   <= 1'b0;
            hsync_c1    <= 1'b0;
            vsync_c1    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignment makes a same-cycle write to this
            // address land after the read, giving read-before-write.
            rd_data_q   <= mem[rd_idx];
            glyph_row_q <= rel_y[3:0];
            x_bit_c1    <= rel_x[2:0];
            in_win_c1   <= in_win_c0;
            active_c1   <= video_active_in;
            hsync_c1    <= hsync_in;
            vsync_c1    <= vsync_in;
        end
    end

    // ROM address: blank glyph and row 0 outside the window
    assign char_code = in_win_c1 ? rd_data_q : BLANK_CHAR;
    assign char_row  = in_win_c1 ? glyph_row_q : 4'h0;

    // C2 stage: capture the ROM row alongside the delayed pixel attributes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_data_q <= '0;
            x_bit_c2   <= '0;
            in_win_c2  <= 1'b0;
            active_c2  <= 1'b0;
            hsync_c2   <= 1'b0;
            vsync_c2   <= 1'b0;
        end else begin
            row_data_q <= row_data;
            x_bit_c2   <= x_bit_c1;
            in_win_c2  <= in_win_c1;
            active_c2  <= active_c1;
            hsync_c2   <= hsync_c1;
            vsync_c2   <= vsync_c1;
        end
    end

    // Bit 7 of the glyph row is the leftmost pixel of the cell
    assign text_on          = row_data_q[3'd7 - x_bit_c2] & in_win_c2 & active_c2;
    assign video_active_out = active_c2;
    assign hsync_out        = hsync_c2;
    assign vsync_out        = vsync_c2;

endmodule

// File: tb/tb_text_overlay_renderer.sv
// Directed testbench for text_overlay_renderer with a small character ROM
// model on the row_data return path and a shadow copy of the buffer.
module tb_text_overlay_renderer;

    localparam int COLS  = 32;
    localparam int ROWS  = 2;
    localparam int NCELL = COLS * ROWS;
    localparam int AW    = 7;  // one spare bit so out-of-range addresses exist

    logic          clk = 1'b0;
    logic          rst_n;
    logic [9:0]    pixel_x;
    logic [9:0]    pixel_y;
    logic          video_active_in;
    logic          hsync_in;
    logic          vsync_in;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          clear;
    logic          busy;
    logic [7:0]    char_code;
    logic [3:0]    char_row;
    logic [7:0]    row_data;
    logic          text_on;
    logic          video_active_out;
    logic          hsync_out;
    logic          vsync_out;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [7:0]    model_mem [NCELL];

    always #5 clk = ~clk;

    text_overlay_renderer #(
        .COLS(COLS), .ROWS(ROWS), .ADDR_W(AW),
        .ORIGIN_X(16), .ORIGIN_Y(8), .BLANK_CHAR(8'h20)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_active_in(video_active_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clear(clear), .busy(busy),
        .char_code(char_code), .char_row(char_row), .row_data(row_data),
        .text_on(text_on), .video_active_out(video_active_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    // Character ROM model: blank glyph for 8'h20, 'A' row 0 = 8'b00111100,
    // anything else a code/row mix.
    function automatic logic [7:0] rom(input logic [7:0] code, input logic [3:0] row);
        if (code == 8'h20) return 8'h00;
        if (code == 8'h41 && row == 4'd0) return 8'h3C;
        return code ^ {row, row};
    endfunction

    assign row_data = rom(char_code, char_row);

    function automatic int cx(input int idx);
        return 16 + (idx % COLS) * 8;
    endfunction

    function automatic int cy(input int idx);
        return 8 + (idx / COLS) * 16;
    endfunction

    function automatic logic in_win(input int x, input int y);
        return (x >= 16) && (x < 16 + 8 * COLS) && (y >= 8) && (y < 8 + 16 * ROWS);
    endfunction

    function automatic logic [7:0] exp_code(input int x, input int y);
        if (!in_win(x, y)) return 8'h20;
        return model_mem[((y - 8) / 16) * COLS + (x - 16) / 8];
    endfunction

    function automatic logic [3:0] exp_row(input int x, input int y);
        if (!in_win(x, y)) return 4'h0;
        return 4'((y - 8) % 16);
    endfunction

    function automatic logic exp_text(input int x, input int y, input logic act);
        logic [7:0] g;
        if (!in_win(x, y) || !act) return 1'b0;
        g = rom(exp_code(x, y), exp_row(x, y));
        return g[7 - ((x - 16) % 8)];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int x, input int y, input logic act, input logic hs, input logic vs);
        pixel_x         = 10'(x);
        pixel_y         = 10'(y);
        video_active_in = act;
        hsync_in        = hs;
        vsync_in        = vs;
    endtask

    task automatic write_cell(input int addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        step();
        wr_en   = 1'b0;
        if (addr < NCELL) model_mem[addr] = data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; clear = 1'b0; wr_addr = '0; wr_data = '0;
        set_pix(20, 10, 1'b1, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (text_on !== 1'b0) begin n_fail++; $display("FAIL reset_text_on: got %b want 0", text_on); end
        n_checks++; if (hsync_out !== 1'b0) begin n_fail++; $display("FAIL reset_hsync: got %b want 0", hsync_out); end
        n_checks++; if (vsync_out !== 1'b0) begin n_fail++; $display("FAIL reset_vsync: got %b want 0", vsync_out); end
        n_checks++; if (video_active_out !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", video_active_out); end
        n_checks++; if (char_code !== 8'h20) begin n_fail++; $display("FAIL reset_char_code: got %h want 20", char_code); end
        n_checks++; if (char_row !== 4'h0) begin n_fail++; $display("FAIL reset_char_row: got %h want 0", char_row); end
        #3 rst_n = 1'b1;
        set_pix(0, 0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", busy); end
        n_checks++; if (char_code !== 8'h20) begin n_fail++; $display("FAIL post_reset_char_code: got %h want 20", char_code); end
    endtask

    task automatic test_glyph();
        logic [7:0] lit;
        lit = 8'b00111100;
        write_cell(0, 8'h41);
        for (int c = 0; c < 10; c++) begin
            if (c >= 1 && c <= 8) begin
                n_checks++; if (char_code !== 8'h41) begin n_fail++; $display("FAIL glyph_code x=%0d: got %h want 41", 15 + c, char_code); end
                n_checks++; if (char_row !== 4'h0) begin n_fail++; $display("FAIL glyph_row x=%0d: got %h want 0", 15 + c, char_row); end
            end
            if (c >= 2) begin
                n_checks++; if (text_on !== lit[9 - c]) begin n_fail++; $display("FAIL glyph_text x=%0d: got %b want %b", 14 + c, text_on, lit[9 - c]); end
            end
            if (c < 8) set_pix(16 + c, 8, 1'b1, 1'b0, 1'b0);
            else set_pix(0, 0, 1'b0, 1'b0, 1'b0);
            step();
        end
    endtask

    task automatic test_outside();
        int xs[6] = '{15, 16, 272, 16, 271, 17};
        int ys[6] = '{8, 40, 8, 7, 39, 8};
        write_cell(63, 8'h5A);
        for (int c = 0; c < 8; c++) begin
            if (c >= 1 && c <= 6) begin
                n_checks++; if (char_code !== exp_code(xs[c-1], ys[c-1])) begin n_fail++; $display("FAIL outside_code (%0d,%0d): got %h want %h", xs[c-1], ys[c-1], char_code, exp_code(xs[c-1], ys[c-1])); end
                n_checks++; if (char_row !== exp_row(xs[c-1], ys[c-1])) begin n_fail++; $display("FAIL outside_row (%0d,%0d): got %h want %h", xs[c-1], ys[c-1], char_row, exp_row(xs[c-1], ys[c-1])); end
            end
            if (c >= 2) begin
                n_checks++; if (text_on !== exp_text(xs[c-2], ys[c-2], 1'b1)) begin n_fail++; $display("FAIL outside_text (%0d,%0d): got %b want %b", xs[c-2], ys[c-2], text_on, exp_text(xs[c-2], ys[c-2], 1'b1)); end
            end
            if (c < 6) set_pix(xs[c], ys[c], 1'b1, 1'b0, 1'b0);
            else set_pix(0, 0, 1'b0, 1'b0, 1'b0);
            step();
        end
    endtask

    task automatic test_sync();
        logic [11:0] hs_pat;
        logic [11:0] vs_pat;
        logic [11:0] act_pat;
        hs_pat  = 12'b101100111010;
        vs_pat  = 12'b110010011100;
        act_pat = 12'b111101101111;
        write_cell(1, 8'h5A);
        for (int c = 0; c < 14; c++) begin
            if (c >= 2) begin
                n_checks++; if (hsync_out !== hs_pat[c-2]) begin n_fail++; $display("FAIL sync_hsync k=%0d: got %b want %b", c - 2, hsync_out, hs_pat[c-2]); end
                n_checks++; if (vsync_out !== vs_pat[c-2]) begin n_fail++; $display("FAIL sync_vsync k=%0d: got %b want %b", c - 2, vsync_out, vs_pat[c-2]); end
                n_checks++; if (video_active_out !== act_pat[c-2]) begin n_fail++; $display("FAIL sync_active k=%0d: got %b want %b", c - 2, video_active_out, act_pat[c-2]); end
                n_checks++; if (text_on !== exp_text(14 + c, 8, act_pat[c-2])) begin n_fail++; $display("FAIL sync_text k=%0d: got %b want %b", c - 2, text_on, exp_text(14 + c, 8, act_pat[c-2])); end
            end
            if (c < 12) set_pix(16 + c, 8, act_pat[c], hs_pat[c], vs_pat[c]);
            else set_pix(0, 0, 1'b0, 1'b0, 1'b0);
            step();
        end
    endtask

    task automatic test_clear();
        int busy_cycles;
        int i;
        for (int k = 0; k < NCELL; k++) write_cell(k, 8'h41);
        // write and clear in the same idle cycle: the write lands first
        wr_en = 1'b1; wr_addr = 7'd63; wr_data = 8'h55; clear = 1'b1;
        step();
        wr_en = 1'b0; clear = 1'b0;
        model_mem[63] = 8'h55;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy_rise: got %b want 1", busy); end
        busy_cycles = 0;
        i = 0;
        while (busy === 1'b1 && i < 200) begin
            busy_cycles++;
            if (i == 1) begin
                n_checks++; if (char_code !== 8'h55) begin n_fail++; $display("FAIL clear_read_during: got %h want 55", char_code); end
            end
            if (i == 0) set_pix(cx(63), cy(63), 1'b1, 1'b0, 1'b0);
            else set_pix(0, 0, 1'b0, 1'b0, 1'b0);
            clear = (i == 30);
            if (i == 40) begin wr_en = 1'b1; wr_addr = 7'd5; wr_data = 8'h77; end
            else wr_en = 1'b0;
            step();
            i++;
        end
        clear = 1'b0; wr_en = 1'b0;
        n_checks++; if (busy_cycles != 64) begin n_fail++; $display("FAIL clear_busy_cycles: got %0d want 64", busy_cycles); end
        for (int k = 0; k < NCELL; k++) model_mem[k] = 8'h20;
        for (int c = 0; c <= NCELL; c++) begin
            if (c >= 1) begin
                n_checks++; if (char_code !== 8'h20) begin n_fail++; $display("FAIL clear_cell_%0d: got %h want 20", c - 1, char_code); end
            end
            if (c < NCELL) set_pix(cx(c), cy(c), 1'b1, 1'b0, 1'b0);
            else set_pix(0, 0, 1'b0, 1'b0, 1'b0);
            step();
        end
    endtask

    task automatic test_range_rbw();
        write_cell(64, 8'h99);
        write_cell(127, 8'h98);
        set_pix(cx(0), cy(0), 1'b1, 1'b0, 1'b0);
        step();
        n_checks++; if (char_code !== 8'h20) begin n_fail++; $display("FAIL range_cell0: got %h want 20", char_code); end
        set_pix(cx(63), cy(63), 1'b1, 1'b0, 1'b0);
        step();
        n_checks++; if (char_code !== 8'h20) begin n_fail++; $display("FAIL range_cell63: got %h want 20", char_code); end
        // same-cycle write and read of cell 3
        wr_en = 1'b1; wr_addr = 7'd3; wr_data = 8'h42;
        set_pix(cx(3), cy(3), 1'b1, 1'b0, 1'b0);
        step();
        wr_en = 1'b0;
        model_mem[3] = 8'h42;
        n_checks++; if (char_code !== 8'h20) begin n_fail++; $display("FAIL rbw_old: got %h want 20", char_code); end
        step();
        n_checks++; if (char_code !== 8'h42) begin n_fail++; $display("FAIL rbw_new: got %h want 42", char_code); end
        set_pix(0, 0, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_reset_mid();
        write_cell(63, 8'h41);
        clear = 1'b1;
        step();
        clear = 1'b0;
        // 'A' row 0, third pixel of the cell: lit
        set_pix(cx(63) + 2, cy(63), 1'b1, 1'b1, 1'b1);
        repeat (4) step();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", busy); end
        n_checks++; if (text_on !== 1'b1) begin n_fail++; $display("FAIL mid_text_before: got %b want 1", text_on); end
        n_checks++; if (hsync_out !== 1'b1) begin n_fail++; $display("FAIL mid_hsync_before: got %b want 1", hsync_out); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        n_checks++; if (text_on !== 1'b0) begin n_fail++; $display("FAIL mid_rst_text: got %b want 0", text_on); end
        n_checks++; if (hsync_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_hsync: got %b want 0", hsync_out); end
        n_checks++; if (vsync_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_vsync: got %b want 0", vsync_out); end
        n_checks++; if (video_active_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_active: got %b want 0", video_active_out); end
        #2 rst_n = 1'b1;
        set_pix(0, 0, 1'b0, 1'b0, 1'b0);
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle_busy: got %b want 0", busy); end
        // aborted clear leaves the tail of the buffer untouched
        set_pix(cx(63), cy(63), 1'b1, 1'b0, 1'b0);
        step();
        n_checks++; if (char_code !== 8'h41) begin n_fail++; $display("FAIL mid_partial_cell63: got %h want 41", char_code); end
        // idle FSM accepts external writes again
        write_cell(10, 8'h33);
        set_pix(cx(10), cy(10), 1'b1, 1'b0, 1'b0);
        step();
        n_checks++; if (char_code !== 8'h33) begin n_fail++; $display("FAIL mid_write_after: got %h want 33", char_code); end
        set_pix(0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < NCELL; k++) model_mem[k] = 8'h20;
        test_reset();
        test_glyph();
        test_outside();
        test_sync();
        test_clear();
        test_range_rbw();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
